// File: rtl/psi_serializer.sv
// Parallel-to-serial engine: req/grant FIFO front end, LANES-wide MSB-first shifter.
// Optional per-lane even-parity trailer beat is enabled by defining PSI_PARITY_EN.
module psi_serializer #(
    parameter int unsigned DATASIZE = 32,
    parameter int unsigned LANES    = 1,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDRBITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] parallel_data_in,
    input  logic                req,
    output logic                grant,
    input  logic                flush,
    output logic                full,
    output logic                empty,
    output logic [LANES-1:0]    serial_out,
    output logic                serial_valid,
    output logic                sof,
    output logic                eof,
    output logic [15:0]         word_cnt
);

    localparam int unsigned BEATS = DATASIZE / LANES;
    localparam int unsigned BEATW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CNTW  = ADDRBITS + 1;

`ifdef PSI_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t              state;
    logic [DATASIZE-1:0] mem [DEPTH];
    logic [ADDRBITS-1:0] wptr, rptr;
    logic [CNTW-1:0]     count, count_next;
    logic [DATASIZE-1:0] sr, head;
    logic [BEATW-1:0]    beat, next_beat;
    logic                wr, pop, last_beat, word_end;
`ifdef PSI_PARITY_EN
    logic [LANES-1:0]    par;
`endif

    // Writes are refused while full or flushing, even if a pop frees a slot this cycle.
    assign grant     = req & ~full & ~flush;
    assign wr        = grant;
    assign head      = mem[rptr];
    assign next_beat = beat + BEATW'(1);
    assign last_beat = (state == SHIFT) && (beat == BEATW'(BEATS - 1));
`ifdef PSI_PARITY_EN
    assign word_end  = (state == PAR);
`else
    assign word_end  = last_beat;
`endif
    assign pop = ~empty & ~flush & ((state == IDLE) | word_end);

    always_comb begin
        count_next = count;
        if (wr && !pop)
            count_next = count + CNTW'(1);
        else if (!wr && pop)
            count_next = count - CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr] <= parallel_data_in;
    end

    // FIFO bookkeeping; full/empty kept as flags that track the count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wr)
                wptr <= wptr + ADDRBITS'(1);
            if (pop)
                rptr <= rptr + ADDRBITS'(1);
            count <= count_next;
            full  <= (count_next == CNTW'(DEPTH));
            empty <= (count_next == CNTW'(0));
        end
    end

    // Shifter FSM; sr holds the bits still to be sent after the current beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sr           <= '0;
            beat         <= '0;
            serial_out   <= '0;
            serial_valid <= 1'b0;
            sof          <= 1'b0;
            eof          <= 1'b0;
            word_cnt     <= '0;
`ifdef PSI_PARITY_EN
            par          <= '0;
`endif
        end else begin
            if (eof)
                word_cnt <= word_cnt + 16'd1;
            if (pop) begin
                state        <= SHIFT;
                sr           <= head << LANES;
                beat         <= '0;
                serial_out   <= head[DATASIZE-1 -: LANES];
                serial_valid <= 1'b1;
                sof          <= 1'b1;
`ifdef PSI_PARITY_EN
                par          <= head[DATASIZE-1 -: LANES];
                eof          <= 1'b0;
`else
                eof          <= (BEATS == 1);
`endif
            end else begin
                case (state)
                    SHIFT: begin
                        if (!last_beat) begin
                            sr           <= sr << LANES;
                            beat         <= next_beat;
                            serial_out   <= sr[DATASIZE-1 -: LANES];
                            serial_valid <= 1'b1;
                            sof          <= 1'b0;
`ifdef PSI_PARITY_EN
                            par          <= par ^ sr[DATASIZE-1 -: LANES];
                            eof          <= 1'b0;
`else
                            eof          <= (next_beat == BEATW'(BEATS - 1));
`endif
                        end else begin
`ifdef PSI_PARITY_EN
                            state        <= PAR;
                            serial_out   <= par;
                            serial_valid <= 1'b1;
                            sof          <= 1'b0;
                            eof          <= 1'b1;
`else
                            state        <= IDLE;
                            serial_out   <= '0;
                            serial_valid <= 1'b0;
                            sof          <= 1'b0;
                            eof          <= 1'b0;
`endif
                            sr           <= '0;
                            beat         <= '0;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        sr           <= '0;
                        beat         <= '0;
                        serial_out   <= '0;
                        serial_valid <= 1'b0;
                        sof          <= 1'b0;
                        eof          <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psi_serializer.sv
// Randomized bench for psi_serializer against a word-queue / beat-position reference model.
module tb_psi_serializer;

    localparam int unsigned DATASIZE = 32;
    localparam int unsigned LANES    = 4;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned ADDRBITS = 4;
    localparam int          BEATS    = DATASIZE / LANES;
`ifdef PSI_PARITY_EN
    localparam int          WC       = BEATS + 1;
`else
    localparam int          WC       = BEATS;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [DATASIZE-1:0] din;
    logic                req, flush;
    logic                grant, full, empty, serial_valid, sof, eof;
    logic [LANES-1:0]    serial_out;
    logic [15:0]         word_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: queued words, word on the wire and cycle position within it.
    logic [DATASIZE-1:0] mq [$];
    logic [DATASIZE-1:0] cur;
    bit                  busy;
    int                  pos;
    logic [15:0]         wcnt;

    psi_serializer #(
        .DATASIZE(DATASIZE), .LANES(LANES), .DEPTH(DEPTH), .ADDRBITS(ADDRBITS)
    ) dut (
        .clk(clk), .rst(rst), .parallel_data_in(din), .req(req), .grant(grant),
        .flush(flush), .full(full), .empty(empty), .serial_out(serial_out),
        .serial_valid(serial_valid), .sof(sof), .eof(eof), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LANES-1:0] slice(input logic [DATASIZE-1:0] w, input int k);
        logic [DATASIZE-1:0] s;
        s = w >> (DATASIZE - LANES * (k + 1));
        return LANES'(s);
    endfunction

    function automatic logic [LANES-1:0] lane_parity(input logic [DATASIZE-1:0] w);
        logic [LANES-1:0] p;
        p = '0;
        for (int j = 0; j < DATASIZE; j++)
            p[j % LANES] ^= w[j];
        return p;
    endfunction

    function automatic logic [LANES-1:0] exp_out();
        if (!busy) return '0;
        if (pos < BEATS) return slice(cur, pos);
        return lane_parity(cur);
    endfunction

    task automatic model_reset();
        mq.delete();
        busy = 0;
        pos  = 0;
        cur  = '0;
        wcnt = '0;
    endtask

    task automatic compare_all(input logic r, input logic f);
        check("grant", 32'(grant), 32'(r && (mq.size() < DEPTH) && !f));
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("serial_valid", 32'(serial_valid), 32'(busy));
        check("sof", 32'(sof), 32'(busy && pos == 0));
        check("eof", 32'(eof), 32'(busy && pos == WC - 1));
        check("serial_out", 32'(serial_out), 32'(exp_out()));
        check("word_cnt", 32'(word_cnt), 32'(wcnt));
    endtask

    task automatic model_edge(input logic r, input logic [DATASIZE-1:0] d, input logic f);
        bit g, wend;
        g    = r && (mq.size() < DEPTH) && !f;
        wend = busy && (pos == WC - 1);
        if (wend) wcnt++;
        if (!f && mq.size() > 0 && (!busy || wend)) begin
            cur  = mq.pop_front();
            pos  = 0;
            busy = 1;
        end else if (busy) begin
            if (wend) busy = 0;
            else pos++;
        end
        if (f) mq.delete();
        else if (g) mq.push_back(d);
    endtask

    task automatic step(input logic r, input logic [DATASIZE-1:0] d, input logic f);
        req = r; din = d; flush = f;
        #1;
        compare_all(r, f);
        @(posedge clk);
        model_edge(r, d, f);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; flush = 1'b0; din = '0;
        model_reset();
        #2;
        compare_all(1'b0, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;

        // Single word, then two back-to-back words.
        step(1'b1, 32'hA5A50F0F, 1'b0);
        idle(WC + 4);
        step(1'b1, 32'h12345678, 1'b0);
        step(1'b1, 32'h9ABCDEF0, 1'b0);
        idle(2 * WC + 4);

        // Hold req until the FIFO saturates, then drain.
        for (int i = 0; i < 30; i++) step(1'b1, $urandom, 1'b0);
        idle(DEPTH * WC + 8);

        // Five words queued, flush partway through the first.
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0);
        idle(2);
        step(1'b0, '0, 1'b1);
        idle(WC + 4);

        // Asynchronous reset at beat 3 of a word, then a clean word.
        step(1'b1, 32'hC3C3_5A5A, 1'b0);
        for (int i = 0; i < 20 && !(busy && pos == 3); i++) idle(1);
        check("reached_beat3", 32'(busy && pos == 3), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all(1'b0, 1'b0);
        @(negedge clk) rst = 1'b0;
        step(1'b1, 32'hFFFFFFFF, 1'b0);
        idle(WC + 4);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 9) < 6), $urandom, 1'($urandom_range(0, 49) == 0));
        idle(DEPTH * WC + 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
